// File: rtl/dcl_pkg.sv
// Shared constants, divider FSM state type and duty-width helper for the duty meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dcl_pkg;

    localparam int DUTY_SCALE_DEF = 10000;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        DONE
    } div_state_t;

    // Bits needed to hold 0..scale inclusive.
    function automatic int duty_width(input int scale);
        return $clog2(scale + 1);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// Latency: NW cycles after start; quotient valid the cycle after done.
// Backpressure: none; start must only be issued while idle.
//
// Ports: start loads num/den; done is high during the final iteration;
// quo is the low QW bits of the NW-bit quotient register.
module seq_divider #(
    parameter int NW = 30,
    parameter int DW = 16,
    parameter int QW = NW
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [NW-1:0] num,
    input  logic [DW-1:0] den,
    output logic          done,
    output logic [QW-1:0] quo
);

    localparam int CW = $clog2(NW + 1);

    logic [NW-1:0] quo_q;   // dividend shifts out of the top, quotient bits in at the bottom
    logic [DW-1:0] rem_q;
    logic [DW-1:0] den_q;
    logic [CW-1:0] cnt_q;   // iterations remaining
    logic          run_q;

    logic [DW:0] rem_sh;
    logic [DW:0] diff;

    assign rem_sh = {rem_q, quo_q[NW-1]};
    assign diff   = rem_sh - {1'b0, den_q};   // MSB set means the trial subtract went negative
    assign done   = run_q & (cnt_q == CW'(1));
    assign quo    = quo_q[QW-1:0];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            quo_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            quo_q <= num;
            rem_q <= '0;
            den_q <= den;
            cnt_q <= CW'(NW);
            run_q <= 1'b1;
        end else if (run_q) begin
            if (!diff[DW]) begin
                rem_q <= diff[DW-1:0];
                quo_q <= {quo_q[NW-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh[DW-1:0];
                quo_q <= {quo_q[NW-2:0], 1'b0};
            end
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/duty_meter_core.sv
// Measures period and high time of async input ft and computes duty = high*DUTY_SCALE/period.
// Latency: NW+3 cycles from the detected rise to valid_o (NW = CNT_W + duty width).
// Backpressure: none; one-deep pending slot, overwritten with an overrun_o pulse when full.
//
// Ports: clk/clr (async active-high), ft input; period_o/high_o/duty_o update together
// with a valid_o pulse; busy_o while dividing; no_signal_o while the input has timed out.
module duty_meter_core
    import dcl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DUTY_SCALE  = DUTY_SCALE_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                                 clk,
    input  logic                                 clr,
    input  logic                                 ft,
    output logic [CNT_W-1:0]                     period_o,
    output logic [CNT_W-1:0]                     high_o,
    output logic [duty_width(DUTY_SCALE)-1:0]    duty_o,
    output logic                                 valid_o,
    output logic                                 busy_o,
    output logic                                 overrun_o,
    output logic                                 no_signal_o
);

    localparam int SW = duty_width(DUTY_SCALE);
    localparam int NW = CNT_W + SW;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [SW-1:0]    DUTY_FULL = SW'(DUTY_SCALE);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_prev;
    logic                   rise;
    logic [CNT_W-1:0]       cnt_t;
    logic [CNT_W-1:0]       cnt_h;
    logic                   armed;
    logic                   timeout_hit;
    logic                   snap_ok;

    div_state_t             state;
    logic                   pend_vld;
    logic [CNT_W-1:0]       pend_t;
    logic [CNT_W-1:0]       pend_h;
    logic [CNT_W-1:0]       div_t;
    logic [CNT_W-1:0]       div_h;
    logic                   force_pend;
    logic                   force_lvl;
    logic                   start_pend;
    logic                   start_new;
    logic                   to_pend;

    logic                   div_start;
    logic [NW-1:0]          div_num;
    logic                   div_done;
    logic [SW-1:0]          div_quo;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_prev;

    // A rise on the timeout cycle is treated as a normal capture instead.
    assign timeout_hit = (cnt_t == CNT_W'(TIMEOUT_CYC)) & ~rise;
    // Arming rises and saturated periods never reach the divider.
    assign snap_ok     = rise & armed & (cnt_t != CNT_MAX);

    // Pending slot has priority over a same-cycle capture; a forced result beats both.
    assign start_pend = (state == IDLE) & ~force_pend & pend_vld;
    assign start_new  = (state == IDLE) & ~force_pend & ~pend_vld & snap_ok;
    assign to_pend    = snap_ok & ~start_new;

    assign div_start = (state == LOAD);
    assign div_num   = NW'(div_h) * NW'(DUTY_SCALE);
    assign busy_o    = (state != IDLE);

    // Synchroniser, period/high counters and arming.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q      <= '0;
            s_prev      <= 1'b0;
            cnt_t       <= '0;
            cnt_h       <= '0;
            armed       <= 1'b0;
            no_signal_o <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ft};
            s_prev <= s;
            if (rise) begin
                // The rise cycle itself is the first high cycle of the new period.
                cnt_t       <= CNT_W'(1);
                cnt_h       <= CNT_W'(1);
                armed       <= 1'b1;
                no_signal_o <= 1'b0;
            end else begin
                if (cnt_t != CNT_MAX) begin
                    cnt_t <= cnt_t + CNT_W'(1);
                end
                if (s && (cnt_h != CNT_MAX)) begin
                    cnt_h <= cnt_h + CNT_W'(1);
                end
                if (timeout_hit) begin
                    armed       <= 1'b0;
                    no_signal_o <= 1'b1;
                end
            end
        end
    end

    // Divider control, pending slot, forced timeout result and output registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            pend_vld   <= 1'b0;
            pend_t     <= '0;
            pend_h     <= '0;
            div_t      <= '0;
            div_h      <= '0;
            force_pend <= 1'b0;
            force_lvl  <= 1'b0;
            period_o   <= '0;
            high_o     <= '0;
            duty_o     <= '0;
            valid_o    <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (force_pend) begin
                        period_o   <= '0;
                        high_o     <= '0;
                        duty_o     <= force_lvl ? DUTY_FULL : '0;
                        valid_o    <= 1'b1;
                        force_pend <= 1'b0;
                    end else if (start_pend) begin
                        div_t    <= pend_t;
                        div_h    <= pend_h;
                        pend_vld <= 1'b0;
                        state    <= LOAD;
                    end else if (start_new) begin
                        div_t <= cnt_t;
                        div_h <= cnt_h;
                        state <= LOAD;
                    end
                end
                LOAD: state <= DIV;
                DIV: begin
                    if (div_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    period_o <= div_t;
                    high_o   <= div_h;
                    duty_o   <= div_quo;
                    valid_o  <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (to_pend) begin
                pend_t    <= cnt_t;
                pend_h    <= cnt_h;
                pend_vld  <= 1'b1;
                // Not an overrun when the old entry leaves for the divider this same cycle.
                overrun_o <= pend_vld & ~start_pend;
            end

            if (timeout_hit) begin
                force_pend <= 1'b1;
                force_lvl  <= s;
                pend_vld   <= 1'b0;
            end
        end
    end

    seq_divider #(
        .NW (NW),
        .DW (CNT_W),
        .QW (SW)
    ) u_div (
        .clk   (clk),
        .clr   (clr),
        .start (div_start),
        .num   (div_num),
        .den   (div_t),
        .done  (div_done),
        .quo   (div_quo)
    );

endmodule

// File: tb/tb_duty_meter_core.sv
// Scoreboard bench for duty_meter_core: default instance u0 plus a CNT_W=8 instance u1.
// Expected triples are queued as stimulus is driven and compared on each valid pulse.
module tb_duty_meter_core;

    localparam int SW = 14;

    logic          clk = 1'b0;
    logic          clr, clr1, ft, ft1;
    logic [15:0]   period0, high0;
    logic [SW-1:0] duty0;
    logic          valid0, busy0, ovr0, nos0;
    logic [7:0]    period1, high1;
    logic [SW-1:0] duty1;
    logic          valid1, busy1, ovr1, nos1;

    always #5 clk = ~clk;

    duty_meter_core u0 (
        .clk(clk), .clr(clr), .ft(ft),
        .period_o(period0), .high_o(high0), .duty_o(duty0),
        .valid_o(valid0), .busy_o(busy0), .overrun_o(ovr0), .no_signal_o(nos0)
    );

    duty_meter_core #(.CNT_W(8), .TIMEOUT_CYC(250)) u1 (
        .clk(clk), .clr(clr1), .ft(ft1),
        .period_o(period1), .high_o(high1), .duty_o(duty1),
        .valid_o(valid1), .busy_o(busy1), .overrun_o(ovr1), .no_signal_o(nos1)
    );

    typedef struct {
        int unsigned p;
        int unsigned h;
        int unsigned d;
    } res_t;

    res_t q0[$];
    res_t q1[$];
    res_t e0, e1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   fixed_mode = 1'b0;
    int   fixed_cnt = 0;
    int   ovr0_cnt = 0;
    int   ovr1_cnt = 0;
    bit   u1_done = 1'b0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse0(input int h, input int l);
        ft = 1'b1;
        cyc(h);
        ft = 1'b0;
        cyc(l);
    endtask

    // Reference duty: integer truncation of high*10000/period.
    task automatic push_meas(input int p, input int h);
        res_t r;
        r.p = p;
        r.h = h;
        r.d = (h * 10000) / p;
        q0.push_back(r);
    endtask

    task automatic push_forced(input bit inst, input int d);
        res_t r;
        r.p = 0;
        r.h = 0;
        r.d = d;
        if (inst) q1.push_back(r);
        else      q0.push_back(r);
    endtask

    always @(negedge clk) begin
        if (!clr) begin
            if (ovr0) ovr0_cnt++;
            if (valid0) begin
                if (fixed_mode) begin
                    fixed_cnt++;
                    check("fast period", period0, 3);
                    check("fast high", high0, 1);
                    check("fast duty", duty0, 3333);
                end else if (q0.size() == 0) begin
                    check("u0 spurious valid", valid0, 0);
                end else begin
                    e0 = q0.pop_front();
                    check("u0 period", period0, e0.p);
                    check("u0 high", high0, e0.h);
                    check("u0 duty", duty0, e0.d);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!clr1) begin
            if (ovr1) ovr1_cnt++;
            if (valid1) begin
                if (q1.size() == 0) begin
                    check("u1 spurious valid", valid1, 0);
                end else begin
                    e1 = q1.pop_front();
                    check("u1 period", period1, e1.p);
                    check("u1 high", high1, e1.h);
                    check("u1 duty", duty1, e1.d);
                end
            end
        end
    end

    // Narrow counters: every period exceeds the timeout, so only forced results appear,
    // with duty following the level of ft at the timeout instant.
    task automatic run_u1();
        push_forced(1, 0);
        cyc(300);
        check("u1 no_signal idle", nos1, 1);
        repeat (3) begin
            push_forced(1, 10000);
            ft1 = 1'b1;
            cyc(10);
            check("u1 no_signal cleared", nos1, 0);
            cyc(270);
            ft1 = 1'b0;
            cyc(20);
        end
        repeat (3) begin
            push_forced(1, 0);
            ft1 = 1'b1;
            cyc(100);
            ft1 = 1'b0;
            cyc(200);
        end
        cyc(50);
        check("u1 queue drained", q1.size(), 0);
        check("u1 overruns", ovr1_cnt, 0);
        u1_done = 1'b1;
    endtask

    initial begin
        int base;
        int fbase;
        clr  = 1'b1;
        clr1 = 1'b1;
        ft   = 1'b0;
        ft1  = 1'b0;
        cyc(3);
        check("rst period", period0, 0);
        check("rst high", high0, 0);
        check("rst duty", duty0, 0);
        check("rst valid", valid0, 0);
        check("rst busy", busy0, 0);
        check("rst overrun", ovr0, 0);
        check("rst no_signal", nos0, 0);
        check("rst u1 no_signal", nos1, 0);
        clr  = 1'b0;
        clr1 = 1'b0;
        fork
            run_u1();
        join_none

        // 30/70 wave: first rise arms, then one result per period.
        base = ovr0_cnt;
        repeat (5) push_meas(100, 30);
        push_forced(0, 0);
        repeat (6) pulse0(30, 70);
        cyc(1100);
        check("p1 queue drained", q0.size(), 0);
        check("p1 overruns", ovr0_cnt - base, 0);
        check("p1 no_signal", nos0, 1);

        // 1/2 wave: period shorter than divider latency.
        base  = ovr0_cnt;
        fbase = fixed_cnt;
        fixed_mode = 1'b1;
        repeat (40) pulse0(1, 2);
        cyc(100);
        fixed_mode = 1'b0;
        check("p2 results seen", (fixed_cnt - fbase) >= 3, 1);
        check("p2 overrun seen", (ovr0_cnt - base) > 0, 1);
        push_forced(0, 0);
        cyc(1050);
        check("p2 queue drained", q0.size(), 0);

        // 50% wave then held high: timeout with the input high.
        repeat (4) push_meas(100, 50);
        push_forced(0, 10000);
        repeat (4) pulse0(50, 50);
        ft = 1'b1;
        cyc(995);
        check("p3 no_signal early", nos0, 0);
        cyc(15);
        check("p3 no_signal set", nos0, 1);
        cyc(190);
        ft = 1'b0;
        cyc(20);
        ft = 1'b1;
        cyc(5);
        check("p3 no_signal cleared", nos0, 0);
        cyc(15);
        ft = 1'b0;
        push_forced(0, 0);
        cyc(1100);
        check("p3 queue drained", q0.size(), 0);

        // Third capture lands on the IDLE cycle with pending full.
        base = ovr0_cnt;
        push_meas(40, 10);
        push_meas(20, 10);
        push_meas(13, 5);
        push_meas(70, 10);
        push_forced(0, 0);
        pulse0(10, 30);
        pulse0(10, 10);
        pulse0(5, 8);
        pulse0(10, 60);
        pulse0(10, 1100);
        check("p4 queue drained", q0.size(), 0);
        check("p4 overruns", ovr0_cnt - base, 0);

        // Reset in the middle of a division.
        push_meas(100, 30);
        pulse0(30, 70);
        pulse0(30, 70);
        ft = 1'b1;
        cyc(15);
        check("p5 busy before clr", busy0, 1);
        check("p5 period before clr", period0, 100);
        clr = 1'b1;
        ft  = 1'b0;
        #1;
        check("p5 clr period", period0, 0);
        check("p5 clr high", high0, 0);
        check("p5 clr duty", duty0, 0);
        check("p5 clr valid", valid0, 0);
        check("p5 clr busy", busy0, 0);
        check("p5 clr no_signal", nos0, 0);
        cyc(3);
        clr = 1'b0;
        repeat (2) push_meas(100, 30);
        cyc(60);
        repeat (3) pulse0(30, 70);
        push_forced(0, 0);
        cyc(1100);
        check("p5 queue drained", q0.size(), 0);

        check("u1 sequence complete", u1_done, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
